dcm_reset_sequencer: RTL and testbench

Supervises the two-stage DCM clock generator. It holds the second DCM in reset until the first DCM has locked, then releases it and waits for lock with a timeout. It retries a bounded number of times and releases the downstream ADC-domain reset only after lock has been stable for a settle period. It also counts loss-of-lock events and flags a fault for software; it sits beside the clock generator and is clocked by BUS_CLK.

---
 rtl/clk_seq_pkg.sv | 29 ++
 rtl/cdc_sync_bit.sv | 22 ++
 rtl/dcm_reset_sequencer.sv | 140 ++++++++++++++
 tb/tb_dcm_reset_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_seq_pkg.sv
// rtl/clk_seq_pkg.sv - shared state encoding and sizing helpers for the DCM reset sequencer
package clk_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOLD      = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_READY     = 3'd4,
        S_FAULT     = 3'd5
    } seq_state_t;

    // Number of bits needed to hold values 0 .. value-1 (at least 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - two-flop single-bit synchronizer into BUS_CLK
module cdc_sync_bit (
    input  logic BUS_CLK,
    input  logic BUS_RST,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second is used by logic
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/dcm_reset_sequencer.sv
// rtl/dcm_reset_sequencer.sv - two-stage DCM reset/lock supervisor with retry, settle and loss counting
module dcm_reset_sequencer
    import clk_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 8,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int SETTLE_CYCLES   = 256,
    parameter int MAX_RETRY       = 3,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 LOCKED_U1,
    input  logic                 LOCKED_U2,
    input  logic                 SOFT_RESTART,
    output logic                 DCM2_RST,
    output logic                 ADC_RST,
    output logic                 CLK_READY,
    output logic                 FAULT,
    output logic [3:0]           RETRY_CNT,
    output logic [CNT_WIDTH-1:0] LOSS_CNT
);

    localparam int TW = clog2(max3(LOCK_TIMEOUT, SETTLE_CYCLES, RST_HOLD_CYCLES));

    localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

    logic          l1_s;
    logic          l2_s;
    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [3:0]    retry_nxt;
    logic          loss_inc;

    cdc_sync_bit u_sync_l1 (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST  (BUS_RST),
        .async_in (LOCKED_U1),
        .sync_out (l1_s)
    );

    cdc_sync_bit u_sync_l2 (
        .BUS_CLK  (BUS_CLK),
        .BUS_RST  (BUS_RST),
        .async_in (LOCKED_U2),
        .sync_out (l2_s)
    );

    // Next-state, retry and loss decisions; global overrides first, then per-state rules
    always_comb begin
        state_nxt = state;
        retry_nxt = RETRY_CNT;
        loss_inc  = 1'b0;
        if (SOFT_RESTART) begin
            state_nxt = S_IDLE;
            retry_nxt = 4'd0;
        end else if (!l1_s && (state != S_IDLE) && (state != S_FAULT)) begin
            state_nxt = S_IDLE;
            loss_inc  = (state == S_READY);
        end else begin
            case (state)
                S_IDLE: begin
                    if (l1_s) state_nxt = S_HOLD;
                end
                S_HOLD: begin
                    if (timer == HOLD_LAST) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (l2_s) begin
                        state_nxt = S_SETTLE;
                    end else if (timer == TIMEOUT_LAST) begin
                        retry_nxt = RETRY_CNT + 4'd1;
                        state_nxt = (retry_nxt == RETRY_LIMIT) ? S_FAULT : S_HOLD;
                    end
                end
                S_SETTLE: begin
                    if (!l2_s) begin
                        state_nxt = S_HOLD;
                    end else if (timer == SETTLE_LAST) begin
                        state_nxt = S_READY;
                        retry_nxt = 4'd0;
                    end
                end
                S_READY: begin
                    if (!l2_s) begin
                        state_nxt = S_HOLD;
                        loss_inc  = 1'b1;
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Shared timer: restarts on every state change or soft restart, otherwise counts and holds at its top
    always_comb begin
        timer_nxt = timer;
        if ((state_nxt != state) || SOFT_RESTART) begin
            timer_nxt = '0;
        end else if (!(&timer)) begin
            timer_nxt = timer + 1'b1;
        end
    end

    // State, counters and outputs decoded from the next state so they all move on the same edge
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state     <= S_IDLE;
            timer     <= '0;
            RETRY_CNT <= 4'd0;
            LOSS_CNT  <= '0;
            DCM2_RST  <= 1'b1;
            ADC_RST   <= 1'b1;
            CLK_READY <= 1'b0;
            FAULT     <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            RETRY_CNT <= retry_nxt;
            if (loss_inc && !(&LOSS_CNT)) begin
                LOSS_CNT <= LOSS_CNT + 1'b1;
            end
            DCM2_RST  <= (state_nxt == S_IDLE) || (state_nxt == S_HOLD) || (state_nxt == S_FAULT);
            ADC_RST   <= (state_nxt != S_READY);
            CLK_READY <= (state_nxt == S_READY);
            FAULT     <= (state_nxt == S_FAULT);
        end
    end

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// tb/tb_dcm_reset_sequencer.sv - directed self-checking bench for dcm_reset_sequencer
module tb_dcm_reset_sequencer;

    logic       BUS_CLK;
    logic       BUS_RST;
    logic       LOCKED_U1;
    logic       LOCKED_U2;
    logic       SOFT_RESTART;
    logic       DCM2_RST;
    logic       ADC_RST;
    logic       CLK_READY;
    logic       FAULT;
    logic [3:0] RETRY_CNT;
    logic [1:0] LOSS_CNT;

    int n_cmp = 0;
    int n_err = 0;

    dcm_reset_sequencer #(
        .RST_HOLD_CYCLES (4),
        .LOCK_TIMEOUT    (20),
        .SETTLE_CYCLES   (8),
        .MAX_RETRY       (2),
        .CNT_WIDTH       (2)
    ) dut (
        .BUS_CLK      (BUS_CLK),
        .BUS_RST      (BUS_RST),
        .LOCKED_U1    (LOCKED_U1),
        .LOCKED_U2    (LOCKED_U2),
        .SOFT_RESTART (SOFT_RESTART),
        .DCM2_RST     (DCM2_RST),
        .ADC_RST      (ADC_RST),
        .CLK_READY    (CLK_READY),
        .FAULT        (FAULT),
        .RETRY_CNT    (RETRY_CNT),
        .LOSS_CNT     (LOSS_CNT)
    );

    initial BUS_CLK = 1'b0;
    always #5 BUS_CLK = ~BUS_CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge BUS_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dcm2"},  DCM2_RST,  1);
        chk({tag, "_adc"},   ADC_RST,   1);
        chk({tag, "_ready"}, CLK_READY, 0);
        chk({tag, "_fault"}, FAULT,     0);
        chk({tag, "_retry"}, RETRY_CNT, 0);
        chk({tag, "_loss"},  LOSS_CNT,  0);
    endtask

    task automatic wait_ready(input string tag);
        int i;
        i = 0;
        while (CLK_READY !== 1'b1 && i < 200) begin
            tick(1);
            i++;
        end
        chk(tag, CLK_READY, 1);
    endtask

    // Called just after an edge while READY; drops U2, checks the loss, relocks and checks READY timing
    task automatic lose_and_relock(input string tag, input int exp_loss);
        LOCKED_U2 = 1'b0;
        tick(2);
        chk({tag, "_still_ready"}, CLK_READY, 1);
        tick(1);
        chk({tag, "_adc"},   ADC_RST,   1);
        chk({tag, "_dcm2"},  DCM2_RST,  1);
        chk({tag, "_ready"}, CLK_READY, 0);
        chk({tag, "_loss"},  LOSS_CNT,  exp_loss);
        LOCKED_U2 = 1'b1;
        tick(12);
        chk({tag, "_not_yet"}, CLK_READY, 0);
        tick(1);
        chk({tag, "_relock"}, CLK_READY, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        BUS_RST      = 1'b1;
        LOCKED_U1    = 1'b0;
        LOCKED_U2    = 1'b0;
        SOFT_RESTART = 1'b0;
        tick(3);
        chk_reset_vals("reset");
        BUS_RST = 1'b0;
        tick(6);
        chk("idle_dcm2", DCM2_RST, 1);

        // Nominal lock-up
        LOCKED_U1 = 1'b1;
        tick(6);
        chk("nom_dcm2_held", DCM2_RST, 1);
        tick(1);
        chk("nom_dcm2_fall", DCM2_RST, 0);
        chk("nom_adc_wait",  ADC_RST,  1);
        tick(3);
        LOCKED_U2 = 1'b1;
        tick(10);
        chk("nom_ready_early", CLK_READY, 0);
        chk("nom_adc_early",   ADC_RST,   1);
        tick(1);
        chk("nom_ready", CLK_READY, 1);
        chk("nom_adc",   ADC_RST,   0);
        chk("nom_retry", RETRY_CNT, 0);
        chk("nom_dcm2",  DCM2_RST,  0);

        // U1 and U2 lost together in READY
        LOCKED_U1 = 1'b0;
        LOCKED_U2 = 1'b0;
        tick(2);
        chk("u1loss_still_ready", CLK_READY, 1);
        tick(1);
        chk("u1loss_ready", CLK_READY, 0);
        chk("u1loss_loss",  LOSS_CNT,  1);
        chk("u1loss_dcm2",  DCM2_RST,  1);
        chk("u1loss_adc",   ADC_RST,   1);
        tick(10);
        chk("u1loss_dcm2_hold", DCM2_RST, 1);
        chk("u1loss_loss_once", LOSS_CNT, 1);

        // Settle abort: U2 high for 5 cycles, then low, then high again
        LOCKED_U1 = 1'b1;
        tick(7);
        chk("abort_wait_dcm2", DCM2_RST, 0);
        LOCKED_U2 = 1'b1;
        tick(5);
        LOCKED_U2 = 1'b0;
        tick(2);
        chk("abort_settle_dcm2",  DCM2_RST,  0);
        chk("abort_settle_ready", CLK_READY, 0);
        tick(1);
        chk("abort_hold_dcm2", DCM2_RST, 1);
        chk("abort_loss",      LOSS_CNT, 1);
        chk("abort_retry",     RETRY_CNT, 0);
        LOCKED_U2 = 1'b1;
        tick(12);
        chk("abort_not_yet", CLK_READY, 0);
        tick(1);
        chk("abort_ready", CLK_READY, 1);
        chk("abort_loss2", LOSS_CNT,  1);

        // Reset while READY
        BUS_RST = 1'b1;
        tick(1);
        chk_reset_vals("rst_ready");
        BUS_RST = 1'b0;
        wait_ready("rst_ready_relock");

        // Repeated U2 loss in READY, including saturation
        lose_and_relock("loss1", 1);
        lose_and_relock("loss2", 2);
        lose_and_relock("loss3", 3);
        lose_and_relock("loss4", 3);

        // Timeout and fault with U2 held low
        LOCKED_U2 = 1'b0;
        BUS_RST   = 1'b1;
        tick(1);
        BUS_RST = 1'b0;
        tick(6);
        chk("to_hold1_dcm2", DCM2_RST, 1);
        tick(1);
        chk("to_wait1_dcm2", DCM2_RST, 0);
        tick(19);
        chk("to_wait1_end_dcm2", DCM2_RST, 0);
        chk("to_wait1_end_retry", RETRY_CNT, 0);
        tick(1);
        chk("to_hold2_dcm2",  DCM2_RST,  1);
        chk("to_hold2_retry", RETRY_CNT, 1);
        chk("to_hold2_fault", FAULT,     0);
        tick(3);
        chk("to_hold2_end_dcm2", DCM2_RST, 1);
        tick(1);
        chk("to_wait2_dcm2", DCM2_RST, 0);
        tick(19);
        chk("to_wait2_end_fault", FAULT, 0);
        tick(1);
        chk("fault_flag",  FAULT,     1);
        chk("fault_dcm2",  DCM2_RST,  1);
        chk("fault_adc",   ADC_RST,   1);
        chk("fault_retry", RETRY_CNT, 2);
        tick(5);
        chk("fault_stays", FAULT, 1);

        SOFT_RESTART = 1'b1;
        tick(1);
        SOFT_RESTART = 1'b0;
        chk("soft_fault", FAULT,     0);
        chk("soft_retry", RETRY_CNT, 0);
        chk("soft_dcm2",  DCM2_RST,  1);
        chk("soft_loss",  LOSS_CNT,  0);
        tick(5);
        chk("soft_wait_dcm2", DCM2_RST, 0);

        // Reset while WAIT_LOCK
        tick(2);
        BUS_RST = 1'b1;
        tick(1);
        chk_reset_vals("rst_wait");
        BUS_RST = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
